ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage sitting directly upstream of the processing domain. Issues byte-wide reads on the 8-bit system bus starting at the current fetch PC and assembles `INSN_BYTES` consecutive bytes little-endian into one instruction word. Hands the word plus its address to the control unit over a valid/ready handshake. Honours the domain's `pc_inhibit` at instruction boundaries and accepts PC redirects from downstream.

## Interface
Parameters:
- `INSN_BYTES`, default 4: bytes per instruction, range 2–8.
- `RESET_PC`, default 64'h0: fetch address after reset.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `pc_inhibit`: input, 1 bit. Suppresses the start of new instruction fetches.
- `redirect_valid`: input, 1 bit. Replaces the fetch PC this cycle.
- `redirect_pc`: input, 64 bits. New fetch address.
- `bus_req`: output, 1 bit. Byte read request.
- `bus_addr`: output, 64 bits. Byte address of the request.
- `bus_ack`: input, 1 bit. Read completion; `bus_data_in` is valid this cycle.
- `bus_data_in`: input, 8 bits. Read data.
- `insn_valid`: output, 1 bit. Assembled instruction available.
- `insn`: output, 8*`INSN_BYTES` bits. Instruction; byte 0 is in `insn[7:0]`.
- `insn_pc`: output, 64 bits. Address of byte 0 of `insn`.
- `insn_ready`: input, 1 bit. Consumer accepts `insn` this cycle.
- `pc`: output, 64 bits. Next byte address to fetch.

## Operation
- All outputs are registered.
- FSM states:
  - IDLE: no request.
  - REQ: `bus_req`=1, waiting for `bus_ack`.
  - HOLD: `insn_valid`=1, waiting for `insn_ready`.
- Reset: state IDLE; `pc`=`bus_addr`=`insn_pc`=`RESET_PC`; `bus_req`=0; `insn_valid`=0; `insn`=0; byte count 0.
- IDLE → REQ when `pc_inhibit`=0. Otherwise stay in IDLE.
- In REQ:
  - `bus_addr`=`pc` and is held stable until ack.
  - On `bus_ack`, byte `bus_data_in` is written to lane `cnt`, `pc` increments by 1 and `cnt` increments by 1.
  - When the last lane is written (`cnt`=`INSN_BYTES`-1), `cnt` returns to 0 and the FSM moves to HOLD with `insn_valid`=1.
  - `pc_inhibit` is ignored mid-instruction; a started instruction always completes.
- In HOLD:
  - No bus request is issued.
  - On `insn_valid & insn_ready`: `insn_valid`←0, `insn_pc`←`pc`, then go to REQ if `pc_inhibit`=0, else IDLE.
- Redirect (`redirect_valid`=1) has highest priority in every state:
  - `pc`, `bus_addr` and `insn_pc` ← `redirect_pc`; `cnt`←0; `insn_valid`←0; `bus_req`←0.
  - Next state is IDLE; normal IDLE rules apply from the following cycle.
  - A coincident `bus_ack` is discarded.
  - A coincident `insn_ready` handshake is discarded: the instruction counts as not delivered.
  - The bus slave tolerates `bus_req` dropping before ack.
- `pc` arithmetic is 64-bit unsigned and wraps from 2^64-1 to 0. There is no alignment requirement.
- Reset asserted mid-operation clears everything to reset values immediately. A partial instruction is lost.

## Timing
- `bus_req` rises 1 cycle after the IDLE → REQ decision.
- With `bus_ack` tied high, one byte is captured per cycle. An instruction is presented `INSN_BYTES` cycles after `bus_req` first rises.
- Back-to-back throughput with `insn_ready`=1: one instruction per `INSN_BYTES`+1 cycles, because HOLD costs one cycle.
- `insn`, `insn_pc` and `insn_valid` are stable while `insn_valid`=1 and `insn_ready`=0.
- Redirect to first `bus_req` of the new stream: 2 cycles, via IDLE, when `pc_inhibit`=0.
- `bus_addr` never changes while `bus_req`=1 and `bus_ack`=0, except on redirect.

## Structure
- Shared package `ifetch_pkg`:
  - `ifetch_state_t` enum (IDLE, REQ, HOLD).
  - `PC_W`=64.
  - `BUS_W`=8.
- Single module; no sub-module. The byte-lane write is a generate/indexed assign inside `ifetch`.
- `cnt` width is $clog2(`INSN_BYTES`).

## Test plan
- Reset with `RESET_PC`=64'h100, `pc_inhibit`=1 for 5 cycles → `bus_req`=0 throughout. Deassert inhibit → `bus_addr`=64'h100 with `bus_req`=1 one cycle later.
- Ack always high, memory bytes 11,22,33,44 at 0x100, `insn_ready`=1 → `insn`=32'h44332211, `insn_pc`=64'h100; next request at 64'h104.
- Ack delayed 3 cycles per byte → `bus_addr` held stable during waits; same `insn` produced after 16 cycles.
- `insn_ready`=0 for 4 cycles in HOLD → `insn_valid` stays 1, `insn` unchanged, `bus_req`=0. Ready rises → transfer, then REQ.
- Redirect to 64'h2000 after 2 of 4 bytes, coincident with `bus_ack` → partial data dropped; next `bus_addr`=64'h2000 and the new `insn_pc`=64'h2000.
- `pc`=64'hFFFF_FFFF_FFFF_FFFE, 4-byte fetch → addresses FFFE, FFFF, 0, 1 in sequence; `insn_pc`=64'hFFFF_FFFF_FFFF_FFFE.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
package ifetch_pkg;

  localparam int PC_W  = 64;
  localparam int BUS_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } ifetch_state_t;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc_val);
    return pc_val + PC_W'(1);
  endfunction

endpackage

// File: rtl/ifetch.sv
// Byte-serial instruction fetch: reads INSN_BYTES bytes from the 8-bit bus,
// packs them little-endian and hands the word downstream over valid/ready.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int              INSN_BYTES = 4,
  parameter logic [PC_W-1:0] RESET_PC   = 64'h0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pc_inhibit,
  input  logic                    redirect_valid,
  input  logic [PC_W-1:0]         redirect_pc,
  output logic                    bus_req,
  output logic [PC_W-1:0]         bus_addr,
  input  logic                    bus_ack,
  input  logic [BUS_W-1:0]        bus_data_in,
  output logic                    insn_valid,
  output logic [8*INSN_BYTES-1:0] insn,
  output logic [PC_W-1:0]         insn_pc,
  input  logic                    insn_ready,
  output logic [PC_W-1:0]         pc
);

  localparam int CNT_W  = $clog2(INSN_BYTES);
  localparam int INSN_W = 8 * INSN_BYTES;

  ifetch_state_t     state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic [PC_W-1:0]   bus_addr_reg, bus_addr_next;
  logic              bus_req_reg, bus_req_next;
  logic              insn_valid_reg, insn_valid_next;
  logic [INSN_W-1:0] insn_reg, insn_next;
  logic [PC_W-1:0]   insn_pc_reg, insn_pc_next;

  logic                  byte_take;
  logic                  last_lane;
  logic [INSN_BYTES-1:0] lane_we;

  // A byte is only kept when no redirect lands in the same cycle.
  assign byte_take = (state_reg == REQ) && bus_ack && !redirect_valid;
  assign last_lane = (cnt_reg == CNT_W'(INSN_BYTES - 1));

  generate
    for (genvar gi = 0; gi < INSN_BYTES; gi++) begin : g_lane
      assign lane_we[gi] = byte_take && (cnt_reg == CNT_W'(gi));
      assign insn_next[gi*8 +: 8] = lane_we[gi] ? bus_data_in : insn_reg[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    pc_next         = pc_reg;
    bus_addr_next   = bus_addr_reg;
    bus_req_next    = bus_req_reg;
    insn_valid_next = insn_valid_reg;
    insn_pc_next    = insn_pc_reg;

    case (state_reg)
      IDLE: begin
        if (!pc_inhibit) begin
          state_next    = REQ;
          bus_req_next  = 1'b1;
          bus_addr_next = pc_reg;
        end
      end
      REQ: begin
        if (bus_ack) begin
          pc_next       = pc_inc(pc_reg);
          bus_addr_next = pc_inc(pc_reg);
          if (last_lane) begin
            cnt_next        = '0;
            state_next      = HOLD;
            insn_valid_next = 1'b1;
            bus_req_next    = 1'b0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (insn_valid_reg && insn_ready) begin
          insn_valid_next = 1'b0;
          insn_pc_next    = pc_reg;
          if (!pc_inhibit) begin
            state_next    = REQ;
            bus_req_next  = 1'b1;
            bus_addr_next = pc_reg;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        bus_req_next = 1'b0;
      end
    endcase

    // Redirect wins over everything, including an ack or handshake this cycle.
    if (redirect_valid) begin
      state_next      = IDLE;
      pc_next         = redirect_pc;
      bus_addr_next   = redirect_pc;
      insn_pc_next    = redirect_pc;
      cnt_next        = '0;
      insn_valid_next = 1'b0;
      bus_req_next    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      pc_reg         <= RESET_PC;
      bus_addr_reg   <= RESET_PC;
      bus_req_reg    <= 1'b0;
      insn_valid_reg <= 1'b0;
      insn_reg       <= '0;
      insn_pc_reg    <= RESET_PC;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      pc_reg         <= pc_next;
      bus_addr_reg   <= bus_addr_next;
      bus_req_reg    <= bus_req_next;
      insn_valid_reg <= insn_valid_next;
      insn_reg       <= insn_next;
      insn_pc_reg    <= insn_pc_next;
    end
  end

  assign bus_req    = bus_req_reg;
  assign bus_addr   = bus_addr_reg;
  assign insn_valid = insn_valid_reg;
  assign insn       = insn_reg;
  assign insn_pc    = insn_pc_reg;
  assign pc         = pc_reg;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: reset, inhibit, ack latency, backpressure,
// redirect with coincident ack, and 64-bit PC wrap.
module tb_ifetch;

  logic        clk;
  logic        reset;
  logic        pc_inhibit;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        bus_req;
  logic [63:0] bus_addr;
  logic        bus_ack;
  logic [7:0]  bus_data_in;
  logic        insn_valid;
  logic [31:0] insn;
  logic [63:0] insn_pc;
  logic        insn_ready;
  logic [63:0] pc;

  int n_checks = 0;
  int n_errors = 0;

  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic [63:0] ack_log[$];

  ifetch #(.INSN_BYTES(4), .RESET_PC(64'h100)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_inhibit     (pc_inhibit),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus_req        (bus_req),
    .bus_addr       (bus_addr),
    .bus_ack        (bus_ack),
    .bus_data_in    (bus_data_in),
    .insn_valid     (insn_valid),
    .insn           (insn),
    .insn_pc        (insn_pc),
    .insn_ready     (insn_ready),
    .pc             (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: fixed table at 0x100.., elsewhere low address byte xor A5.
  function automatic logic [7:0] mem_byte(input logic [63:0] addr);
    case (addr)
      64'h100: return 8'h11;
      64'h101: return 8'h22;
      64'h102: return 8'h33;
      64'h103: return 8'h44;
      default: return addr[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Bus slave: acks after ack_delay idle cycles of a pending request.
  always @(negedge clk) begin
    if (bus_req) begin
      if (wait_cnt == ack_delay) begin
        bus_ack     = 1'b1;
        bus_data_in = mem_byte(bus_addr);
        wait_cnt    = 0;
      end else begin
        bus_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      bus_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  always @(posedge clk) begin
    if (bus_req && bus_ack) ack_log.push_back(bus_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ticks until insn_valid (bounded); also counts bus_addr changes while a request waits.
  task automatic wait_valid(input int max_cycles, output int cycles, output int addr_viol);
    logic        r, k;
    logic [63:0] a;
    cycles    = 0;
    addr_viol = 0;
    while (!insn_valid && cycles < max_cycles) begin
      @(negedge clk);
      #1;
      r = bus_req;
      k = bus_ack;
      a = bus_addr;
      tick();
      cycles++;
      if (r && !k && !redirect_valid && bus_addr !== a) addr_viol++;
    end
  endtask

  initial begin
    int cyc;
    int viol;
    int req_seen;
    logic [31:0] held_insn;

    reset          = 1'b1;
    pc_inhibit     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    insn_ready     = 1'b0;
    bus_ack        = 1'b0;
    bus_data_in    = '0;

    tick();
    tick();
    reset = 1'b0;

    chk("reset_bus_req", 64'(bus_req), 64'd0);
    chk("reset_insn_valid", 64'(insn_valid), 64'd0);
    chk("reset_pc", pc, 64'h100);
    chk("reset_bus_addr", bus_addr, 64'h100);
    chk("reset_insn_pc", insn_pc, 64'h100);
    chk("reset_insn", 64'(insn), 64'd0);

    req_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus_req) req_seen++;
    end
    chk("inhibit_no_req", 64'(req_seen), 64'd0);

    // First fetch: ack every cycle, ready already high.
    pc_inhibit = 1'b0;
    insn_ready = 1'b1;
    tick();
    chk("first_req", 64'(bus_req), 64'd1);
    chk("first_addr", bus_addr, 64'h100);
    $display("txn: request at %h", bus_addr);
    wait_valid(40, cyc, viol);
    chk("fast_latency", 64'(cyc), 64'd4);
    chk("fast_insn", 64'(insn), 64'h44332211);
    chk("fast_insn_pc", insn_pc, 64'h100);
    $display("txn: insn %h at %h after %0d cycles", insn, insn_pc, cyc);
    tick();
    chk("fast_handoff_valid", 64'(insn_valid), 64'd0);
    chk("fast_next_req", 64'(bus_req), 64'd1);
    chk("fast_next_addr", bus_addr, 64'h104);
    chk("fast_next_insn_pc", insn_pc, 64'h104);

    // Redirect back to 0x100 and refetch with slow acks and backpressure.
    ack_delay      = 3;
    insn_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    tick();
    redirect_valid = 1'b0;
    chk("redir1_req", 64'(bus_req), 64'd0);
    chk("redir1_pc", pc, 64'h100);
    tick();
    chk("slow_req", 64'(bus_req), 64'd1);
    chk("slow_addr", bus_addr, 64'h100);
    wait_valid(60, cyc, viol);
    chk("slow_latency", 64'(cyc), 64'd16);
    chk("slow_addr_stable", 64'(viol), 64'd0);
    chk("slow_insn", 64'(insn), 64'h44332211);
    $display("txn: slow insn %h at %h after %0d cycles", insn, insn_pc, cyc);
    held_insn = insn;

    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_valid", 64'(insn_valid), 64'd1);
      chk("hold_insn", 64'(insn), 64'(held_insn));
      chk("hold_no_req", 64'(bus_req), 64'd0);
    end
    ack_delay  = 0;
    insn_ready = 1'b1;
    tick();
    chk("hold_release_valid", 64'(insn_valid), 64'd0);
    chk("hold_release_req", 64'(bus_req), 64'd1);
    chk("hold_release_addr", bus_addr, 64'h104);

    // Two bytes in, redirect on the same edge as the third ack.
    tick();
    tick();
    chk("partial_addr", bus_addr, 64'h106);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    tick();
    redirect_valid = 1'b0;
    chk("redir2_req", 64'(bus_req), 64'd0);
    chk("redir2_pc", pc, 64'h2000);
    chk("redir2_valid", 64'(insn_valid), 64'd0);
    tick();
    chk("redir2_first_req", 64'(bus_req), 64'd1);
    chk("redir2_first_addr", bus_addr, 64'h2000);
    wait_valid(40, cyc, viol);
    chk("redir2_insn", 64'(insn), 64'hA6A7A4A5);
    chk("redir2_insn_pc", insn_pc, 64'h2000);
    $display("txn: insn %h at %h after redirect", insn, insn_pc);
    tick();

    // PC wrap through 2^64-1.
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    ack_log.delete();
    tick();
    chk("wrap_first_addr", bus_addr, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_valid(40, cyc, viol);
    chk("wrap_insn", 64'(insn), 64'hA4A55A5B);
    chk("wrap_insn_pc", insn_pc, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("wrap_pc", pc, 64'h2);
    chk("wrap_ack_count", 64'(ack_log.size()), 64'd4);
    if (ack_log.size() == 4) begin
      chk("wrap_addr0", ack_log[0], 64'hFFFF_FFFF_FFFF_FFFE);
      chk("wrap_addr1", ack_log[1], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("wrap_addr2", ack_log[2], 64'h0);
      chk("wrap_addr3", ack_log[3], 64'h1);
    end
    $display("txn: wrap insn %h at %h", insn, insn_pc);

    // Handshake with inhibit set drops to IDLE and stays there.
    pc_inhibit = 1'b1;
    tick();
    chk("inhibit_after_valid", 64'(insn_valid), 64'd0);
    chk("inhibit_after_req", 64'(bus_req), 64'd0);
    chk("inhibit_after_insn_pc", insn_pc, 64'h2);
    tick();
    chk("inhibit_idle_req", 64'(bus_req), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
